// File: rtl/fir_sm_sink.sv
// Output sink for the FIR engine: FWFT skid FIFO between the FIR's AXI-Stream
// output and the downstream consumer, plus per-frame length/sum statistics.
module fir_sm_sink #(
  parameter int pDATA_WIDTH = 32,
  parameter int DEPTH       = 8,
  parameter int CNT_WIDTH   = 16,
  localparam int AW         = $clog2(DEPTH),
  localparam int LW         = AW + 1
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   clear,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [LW-1:0]          level,
  output logic [CNT_WIDTH-1:0]   frame_len,
  output logic [31:0]            frame_sum,
  output logic                   frame_done,
  output logic                   frame_valid,
  output logic                   len_ovf
);

  logic [pDATA_WIDTH:0]   mem_r [DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [LW-1:0]          level_r;
  logic [CNT_WIDTH-1:0]   run_len_r;
  logic [31:0]            run_sum_r;

  logic                   push_s;
  logic                   pop_s;
  logic                   len_sat_s;
  logic [CNT_WIDTH-1:0]   len_inc_s;
  logic [31:0]            sum_inc_s;
  logic [pDATA_WIDTH:0]   head_s;

  // No full passthrough: readiness depends on stored occupancy only.
  assign s_tready  = (level_r != LW'(DEPTH)) & ~axis_rst;
  assign m_tvalid  = (level_r != {LW{1'b0}});
  assign level     = level_r;
  assign push_s    = s_tvalid & s_tready;
  assign pop_s     = m_tvalid & m_tready;
  assign len_sat_s = (run_len_r == {CNT_WIDTH{1'b1}});
  assign len_inc_s = len_sat_s ? run_len_r : run_len_r + CNT_WIDTH'(1);
  assign sum_inc_s = run_sum_r + 32'(s_tdata);
  assign head_s    = mem_r[rd_ptr_r];

  // FWFT head; outputs forced to zero while empty so reset shows a clean bus.
  always_comb begin
    m_tdata = {pDATA_WIDTH{1'b0}};
    m_tlast = 1'b0;
    if (m_tvalid) begin
      m_tdata = head_s[pDATA_WIDTH-1:0];
      m_tlast = head_s[pDATA_WIDTH];
    end else begin
      m_tdata = {pDATA_WIDTH{1'b0}};
      m_tlast = 1'b0;
    end
  end

  // Storage array write; a push coinciding with clear is dropped.
  always_ff @(posedge axis_clk) begin
    if (push_s && !clear) begin
      mem_r[wr_ptr_r] <= {s_tlast, s_tdata};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Frame statistics track accepted input beats, not output draining.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      run_len_r   <= {CNT_WIDTH{1'b0}};
      run_sum_r   <= 32'd0;
      frame_len   <= {CNT_WIDTH{1'b0}};
      frame_sum   <= 32'd0;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      len_ovf     <= 1'b0;
    end else if (clear) begin
      run_len_r   <= {CNT_WIDTH{1'b0}};
      run_sum_r   <= 32'd0;
      frame_len   <= {CNT_WIDTH{1'b0}};
      frame_sum   <= 32'd0;
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      len_ovf     <= 1'b0;
    end else begin
      frame_done <= push_s & s_tlast;
      if (push_s) begin
        if (len_sat_s) len_ovf <= 1'b1;
        if (s_tlast) begin
          frame_len   <= len_inc_s;
          frame_sum   <= sum_inc_s;
          frame_valid <= 1'b1;
          run_len_r   <= {CNT_WIDTH{1'b0}};
          run_sum_r   <= 32'd0;
        end else begin
          run_len_r   <= len_inc_s;
          run_sum_r   <= sum_inc_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_sm_sink.sv
// Directed bench for fir_sm_sink (DEPTH=8, CNT_WIDTH=4 so saturation is reachable).
module tb_fir_sm_sink;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        s_tready;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic [3:0]  level;
  logic [3:0]  frame_len;
  logic [31:0] frame_sum;
  logic        frame_done;
  logic        frame_valid;
  logic        len_ovf;

  int n_cmp = 0;
  int n_err = 0;

  fir_sm_sink #(.pDATA_WIDTH(32), .DEPTH(8), .CNT_WIDTH(4)) dut (
    .axis_clk(clk), .axis_rst(rst), .clear(clear),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .level(level), .frame_len(frame_len), .frame_sum(frame_sum),
    .frame_done(frame_done), .frame_valid(frame_valid), .len_ovf(len_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        sl;
    logic        mr;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [3:0]  elev;
    logic        efd;
    logic [3:0]  eflen;
    logic [31:0] efsum;
    logic        efv;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; m_tready = 1'b0;
    drive(1'b0, 32'd0, 1'b0);

    // Reset state
    tick(); tick();
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_level", level, 4'd0);
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_len_ovf", len_ovf, 1'b0);
    chk("rst_frame_len", frame_len, 4'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_s_tready", s_tready, 1'b1);

    // Basic pass-through, table driven: fields are inputs then state after the edge
    tbl[0] = '{1'b1, 32'd1, 1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 4'd1, 1'b0, 4'd0, 32'd0,  1'b0};
    tbl[1] = '{1'b1, 32'd2, 1'b0, 1'b1, 1'b1, 32'd2, 1'b0, 4'd1, 1'b0, 4'd0, 32'd0,  1'b0};
    tbl[2] = '{1'b1, 32'd3, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0, 4'd1, 1'b0, 4'd0, 32'd0,  1'b0};
    tbl[3] = '{1'b1, 32'd4, 1'b0, 1'b1, 1'b1, 32'd4, 1'b0, 4'd1, 1'b0, 4'd0, 32'd0,  1'b0};
    tbl[4] = '{1'b1, 32'd5, 1'b1, 1'b1, 1'b1, 32'd5, 1'b1, 4'd1, 1'b1, 4'd5, 32'd15, 1'b1};
    tbl[5] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd5, 32'd15, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].sv, tbl[i].sd, tbl[i].sl);
      m_tready = tbl[i].mr;
      tick();
      chk($sformatf("basic%0d_m_tvalid", i), m_tvalid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("basic%0d_m_tdata", i), m_tdata, tbl[i].ed);
        chk($sformatf("basic%0d_m_tlast", i), m_tlast, tbl[i].el);
      end
      chk($sformatf("basic%0d_level", i), level, tbl[i].elev);
      chk($sformatf("basic%0d_s_tready", i), s_tready, 1'b1);
      chk($sformatf("basic%0d_frame_done", i), frame_done, tbl[i].efd);
      chk($sformatf("basic%0d_frame_len", i), frame_len, tbl[i].eflen);
      chk($sformatf("basic%0d_frame_sum", i), frame_sum, tbl[i].efsum);
      chk($sformatf("basic%0d_frame_valid", i), frame_valid, tbl[i].efv);
    end

    // Full / backpressure: 8 beats fill the FIFO
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'd100 + 32'(i), 1'b0);
      tick();
    end
    chk("full_level", level, 4'd8);
    chk("full_s_tready", s_tready, 1'b0);
    chk("full_head", m_tdata, 32'd100);
    drive(1'b1, 32'd108, 1'b0);
    tick();
    chk("full_hold_level", level, 4'd8);
    chk("full_hold_head", m_tdata, 32'd100);
    // Pop while full: no push that cycle
    m_tready = 1'b1;
    tick();
    chk("fullpop_level", level, 4'd7);
    chk("fullpop_s_tready", s_tready, 1'b1);
    chk("fullpop_head", m_tdata, 32'd101);
    tick();
    chk("steady_level_a", level, 4'd7);
    chk("steady_head_a", m_tdata, 32'd102);
    drive(1'b1, 32'd109, 1'b1);
    tick();
    chk("steady_level_b", level, 4'd7);
    chk("steady_head_b", m_tdata, 32'd103);
    chk("full_frame_done", frame_done, 1'b1);
    chk("full_frame_len", frame_len, 4'd10);
    chk("full_frame_sum", frame_sum, 32'd1045);
    drive(1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("drain%0d_m_tvalid", k), m_tvalid, 1'b1);
      chk($sformatf("drain%0d_m_tdata", k), m_tdata, 32'd103 + 32'(k));
      chk($sformatf("drain%0d_m_tlast", k), m_tlast, (k == 6) ? 1'b1 : 1'b0);
      tick();
      if (k == 0) chk("drain_frame_done_clr", frame_done, 1'b0);
    end
    chk("drain_empty_m_tvalid", m_tvalid, 1'b0);
    chk("drain_empty_level", level, 4'd0);

    // Sum wrap and back-to-back single-beat frames
    drive(1'b1, 32'hFFFF_FFFF, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0002, 1'b1);
    tick();
    chk("wrap_frame_sum", frame_sum, 32'h0000_0001);
    chk("wrap_frame_len", frame_len, 4'd2);
    chk("wrap_frame_done", frame_done, 1'b1);
    drive(1'b1, 32'd7, 1'b1);
    tick();
    chk("single1_done", frame_done, 1'b1);
    chk("single1_len", frame_len, 4'd1);
    chk("single1_sum", frame_sum, 32'd7);
    drive(1'b1, 32'd9, 1'b1);
    tick();
    chk("single2_done", frame_done, 1'b1);
    chk("single2_len", frame_len, 4'd1);
    chk("single2_sum", frame_sum, 32'd9);
    chk("single2_head", m_tdata, 32'd9);
    drive(1'b0, 32'd0, 1'b0);
    tick();
    chk("single_done_drop", frame_done, 1'b0);
    chk("single_level", level, 4'd0);

    // Clear mid-frame with a coincident beat
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd11 + 32'(i), 1'b0);
      tick();
    end
    chk("preclr_level", level, 4'd3);
    drive(1'b1, 32'd14, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    chk("clr_level", level, 4'd0);
    chk("clr_m_tvalid", m_tvalid, 1'b0);
    chk("clr_frame_valid", frame_valid, 1'b0);
    chk("clr_frame_len", frame_len, 4'd0);
    chk("clr_frame_sum", frame_sum, 32'd0);
    chk("clr_s_tready", s_tready, 1'b1);
    drive(1'b1, 32'd20, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b0);
    chk("postclr_level", level, 4'd1);
    chk("postclr_head", m_tdata, 32'd20);
    chk("postclr_frame_len", frame_len, 4'd1);
    chk("postclr_frame_sum", frame_sum, 32'd20);
    m_tready = 1'b1;
    tick();
    chk("postclr_empty", m_tvalid, 1'b0);

    // Length saturation: 20-beat frame with a 4-bit counter
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'(k + 1), (k == 19) ? 1'b1 : 1'b0);
      tick();
      chk($sformatf("sat%0d_m_tdata", k), m_tdata, 32'(k + 1));
      if (k == 14) chk("sat_ovf_before", len_ovf, 1'b0);
      if (k == 15) chk("sat_ovf_after", len_ovf, 1'b1);
    end
    drive(1'b0, 32'd0, 1'b0);
    chk("sat_frame_len", frame_len, 4'd15);
    chk("sat_frame_sum", frame_sum, 32'd210);
    chk("sat_len_ovf", len_ovf, 1'b1);
    chk("sat_frame_done", frame_done, 1'b1);
    tick();
    chk("sat_ovf_sticky", len_ovf, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("sat_ovf_cleared", len_ovf, 1'b0);

    // Reset mid-frame discards buffered beats
    m_tready = 1'b0;
    drive(1'b1, 32'd50, 1'b0);
    tick();
    drive(1'b1, 32'd51, 1'b0);
    tick();
    drive(1'b0, 32'd0, 1'b0);
    chk("prerst_level", level, 4'd2);
    rst = 1'b1;
    #1;
    chk("midrst_level", level, 4'd0);
    chk("midrst_s_tready", s_tready, 1'b0);
    chk("midrst_m_tvalid", m_tvalid, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_release_s_tready", s_tready, 1'b1);
    drive(1'b1, 32'd60, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b0);
    chk("midrst_frame_len", frame_len, 4'd1);
    chk("midrst_frame_sum", frame_sum, 32'd60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
